mont_cmd_sequencer: RTL and testbench

Command sequencer between the Montgomery interface and the Montgomery multiplier core. It accepts 32-bit commands over the port-1 handshake and loads 512-bit operands from the RAM's parallel output into the A/B/M registers. It starts the core and returns the result to the RAM's parallel input. Every command completes with a port-2 done handshake.

---
 rtl/mont_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mont_cmd_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_cmd_sequencer.sv
// rtl/mont_cmd_sequencer.sv - command sequencer between the Montgomery interface, operand RAM and multiplier core
// Optional core watchdog: define MONT_CMD_TIMEOUT_EN to enable the WAIT-state timeout (TIMEOUT_CYCLES).

module mont_cmd_sequencer #(
    parameter int DATA_WIDTH     = 512,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [31:0]           port1_din,
    input  logic                  port1_valid,
    output logic                  port1_read,

    output logic                  port2_valid,
    input  logic                  port2_read,

    output logic [7:0]            status,

    input  logic [DATA_WIDTH-1:0] bram_din,
    input  logic                  bram_din_valid,
    output logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  bram_dout_valid,
    input  logic                  bram_dout_read,

    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_a,
    output logic [DATA_WIDTH-1:0] core_b,
    output logic [DATA_WIDTH-1:0] core_m,
    input  logic [DATA_WIDTH-1:0] core_result,
    input  logic                  core_done
);

    localparam logic [3:0] OP_LOAD_A = 4'h1;
    localparam logic [3:0] OP_LOAD_B = 4'h2;
    localparam logic [3:0] OP_LOAD_M = 4'h3;
    localparam logic [3:0] OP_MULT   = 4'h4;
    localparam logic [3:0] OP_STORE  = 4'h5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    port1_read_q;
    logic                    port2_valid_q;
    logic                    bram_dout_valid_q;
    logic                    core_start_q;
    logic [DATA_WIDTH-1:0]   bram_dout_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH-1:0]   m_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [3:0]              last_opcode_q;
    logic                    err_illegal_q;
    logic                    err_timeout;
    logic [3:0]              opcode_d;
    logic                    unused_bits;

    assign opcode_d = port1_din[31:28];

`ifdef MONT_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic             err_timeout_q;
    logic [CNT_W-1:0] cnt_q;
    assign err_timeout = err_timeout_q;
    assign unused_bits = ^port1_din[27:0];
`else
    assign err_timeout = 1'b0;
    assign unused_bits = ^{port1_din[27:0], (TIMEOUT_CYCLES > 0)};
`endif

    // Command FSM: all outputs are registered here; one-cycle pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q           <= S_IDLE;
            port1_read_q      <= 1'b0;
            port2_valid_q     <= 1'b0;
            bram_dout_valid_q <= 1'b0;
            core_start_q      <= 1'b0;
            bram_dout_q       <= '0;
            a_q               <= '0;
            b_q               <= '0;
            m_q               <= '0;
            result_q          <= '0;
            last_opcode_q     <= 4'h0;
            err_illegal_q     <= 1'b0;
`ifdef MONT_CMD_TIMEOUT_EN
            err_timeout_q     <= 1'b0;
            cnt_q             <= '0;
`endif
        end else begin
            port1_read_q <= 1'b0;
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (port1_valid) begin
                        port1_read_q  <= 1'b1;
                        last_opcode_q <= opcode_d;
                        err_illegal_q <= 1'b0;
`ifdef MONT_CMD_TIMEOUT_EN
                        err_timeout_q <= 1'b0;
`endif
                        case (opcode_d)
                            OP_LOAD_A, OP_LOAD_B, OP_LOAD_M: state_q <= S_LOAD;
                            OP_MULT:                         state_q <= S_START;
                            OP_STORE:                        state_q <= S_STORE;
                            default: begin
                                // Unknown opcode: report and complete without touching the datapath.
                                err_illegal_q <= 1'b1;
                                port2_valid_q <= 1'b1;
                                state_q       <= S_DONE;
                            end
                        endcase
                    end
                end

                S_LOAD: begin
                    if (bram_din_valid) begin
                        case (last_opcode_q)
                            OP_LOAD_A: a_q <= bram_din;
                            OP_LOAD_B: b_q <= bram_din;
                            default:   m_q <= bram_din;
                        endcase
                        port2_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end

                S_START: begin
                    core_start_q <= 1'b1;
`ifdef MONT_CMD_TIMEOUT_EN
                    cnt_q        <= '0;
`endif
                    state_q      <= S_WAIT;
                end

                S_WAIT: begin
                    if (core_done) begin
                        result_q      <= core_result;
                        port2_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end
`ifdef MONT_CMD_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Watchdog expired: result register keeps its previous value.
                        err_timeout_q <= 1'b1;
                        port2_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end

                S_STORE: begin
                    if (!bram_dout_valid_q) begin
                        bram_dout_valid_q <= 1'b1;
                        bram_dout_q       <= result_q;
                    end else if (bram_dout_read) begin
                        bram_dout_valid_q <= 1'b0;
                        port2_valid_q     <= 1'b1;
                        state_q           <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (port2_read) begin
                        port2_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign port1_read      = port1_read_q;
    assign port2_valid     = port2_valid_q;
    assign bram_dout_valid = bram_dout_valid_q;
    assign bram_dout       = bram_dout_q;
    assign core_start      = core_start_q;
    assign core_a          = a_q;
    assign core_b          = b_q;
    assign core_m          = m_q;
    assign status          = {err_illegal_q, err_timeout, 2'b00, last_opcode_q};

endmodule

// File: tb/tb_mont_cmd_sequencer.sv
// tb/tb_mont_cmd_sequencer.sv - directed scoreboard bench for mont_cmd_sequencer

module tb_mont_cmd_sequencer;

    localparam int DW = 512;
    localparam logic [DW-1:0] A_VAL = {64{8'hA5}};
    localparam logic [DW-1:0] B_VAL = {64{8'h5A}};
    localparam logic [DW-1:0] M_VAL = {64{8'hFF}};
    localparam logic [DW-1:0] R_VAL = {16{32'hDEADBEEF}};
    localparam logic [DW-1:0] R_LATE = {16{32'h12345678}};

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   port1_din;
    logic          port1_valid;
    logic          port1_read;
    logic          port2_valid;
    logic          port2_read;
    logic [7:0]    status;
    logic [DW-1:0] bram_din;
    logic          bram_din_valid;
    logic [DW-1:0] bram_dout;
    logic          bram_dout_valid;
    logic          bram_dout_read;
    logic          core_start;
    logic [DW-1:0] core_a;
    logic [DW-1:0] core_b;
    logic [DW-1:0] core_m;
    logic [DW-1:0] core_result;
    logic          core_done;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb[$];

    mont_cmd_sequencer #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .port1_din       (port1_din),
        .port1_valid     (port1_valid),
        .port1_read      (port1_read),
        .port2_valid     (port2_valid),
        .port2_read      (port2_read),
        .status          (status),
        .bram_din        (bram_din),
        .bram_din_valid  (bram_din_valid),
        .bram_dout       (bram_dout),
        .bram_dout_valid (bram_dout_valid),
        .bram_dout_read  (bram_dout_read),
        .core_start      (core_start),
        .core_a          (core_a),
        .core_b          (core_b),
        .core_m          (core_m),
        .core_result     (core_result),
        .core_done       (core_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sb_pop();
        logic [DW-1:0] v;
        v = 'x;
        if (sb.size() > 0) v = sb.pop_front();
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_p1read"}, port1_read, 0);
        check({tag, "_p2valid"}, port2_valid, 0);
        check({tag, "_bdvalid"}, bram_dout_valid, 0);
        check({tag, "_start"}, core_start, 0);
        check({tag, "_status"}, status, 0);
        check({tag, "_bdout"}, bram_dout, 0);
        check({tag, "_a"}, core_a, 0);
        check({tag, "_b"}, core_b, 0);
        check({tag, "_m"}, core_m, 0);
    endtask

    // Present a command for one edge; on return port1_read should be high.
    task automatic send_cmd(input logic [3:0] op);
        port1_din   = {op, 28'h0};
        port1_valid = 1'b1;
        tick();
        check("accept_p1read", port1_read, 1);
        port1_valid = 1'b0;
    endtask

    task automatic ack_done(input string tag);
        check({tag, "_p2valid_hi"}, port2_valid, 1);
        port2_read = 1'b1;
        tick();
        port2_read = 1'b0;
        check({tag, "_p2valid_lo"}, port2_valid, 0);
    endtask

    task automatic load_op(input logic [3:0] op, input logic [DW-1:0] val);
        send_cmd(op);
        sb.push_back(val);
        bram_din       = val;
        bram_din_valid = 1'b1;
        tick();
        bram_din_valid = 1'b0;
        check("load_p1read_lo", port1_read, 0);
        check("load_status", status, {4'h0, op});
    endtask

    initial begin
        int  n;
        bit  bad;
        logic [DW-1:0] exp;

        resetn = 1'b0; port1_din = '0; port1_valid = 1'b0; port2_read = 1'b0;
        bram_din = '0; bram_din_valid = 1'b0; bram_dout_read = 1'b0;
        core_result = '0; core_done = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check_all_zero("reset");

        // Stray strobes while idle must not disturb anything.
        bram_din = R_LATE; bram_din_valid = 1'b1; core_done = 1'b1; core_result = R_LATE;
        tick();
        bram_din_valid = 1'b0; core_done = 1'b0;
        check_all_zero("idle_stray");

        // LOAD_A / LOAD_B / LOAD_M
        load_op(4'h1, A_VAL);
        check("core_a", core_a, sb_pop());
        ack_done("load_a");
        tick();
        check("load_a_p2_once", port2_valid, 0);

        load_op(4'h2, B_VAL);
        check("core_b", core_b, sb_pop());
        ack_done("load_b");
        tick();

        load_op(4'h3, M_VAL);
        check("core_m", core_m, sb_pop());
        check("core_a_persist", core_a, A_VAL);
        ack_done("load_m");
        tick();

        // MULT with a competing command held on port 1 while busy.
        send_cmd(4'h4);
        check("mult_start_early", core_start, 0);
        port1_din = {4'h5, 28'h0};
        port1_valid = 1'b1;
        tick();
        check("mult_start_hi", core_start, 1);
        check("busy_p1read", port1_read, 0);
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (core_start !== 1'b0 || port1_read !== 1'b0 || port2_valid !== 1'b0) bad = 1'b1;
        end
        check("mult_wait_quiet", bad, 0);
        core_result = R_VAL;
        core_done   = 1'b1;
        sb.push_back(R_VAL);
        tick();
        core_done = 1'b0;
        check("mult_done_p2valid", port2_valid, 1);
        check("mult_status", status, 8'h04);
        port1_valid = 1'b0;
        ack_done("mult");
        tick();

        // STORE returns the captured core result.
        send_cmd(4'h5);
        check("store_bdvalid_early", bram_dout_valid, 0);
        tick();
        check("store_bdvalid", bram_dout_valid, 1);
        exp = sb_pop();
        check("store_bdout", bram_dout, exp);
        tick();
        tick();
        check("store_hold_valid", bram_dout_valid, 1);
        check("store_hold_data", bram_dout, exp);
        check("store_hold_p2", port2_valid, 0);
        bram_dout_read = 1'b1;
        tick();
        bram_dout_read = 1'b0;
        check("store_bdvalid_lo", bram_dout_valid, 0);
        ack_done("store");
        tick();

        // Illegal opcode with port2_read already high: one-cycle completion.
        port2_read = 1'b1;
        send_cmd(4'h9);
        check("illegal_status", status, 8'h89);
        check("illegal_p2valid", port2_valid, 1);
        check("illegal_nostart", core_start, 0);
        tick();
        port2_read = 1'b0;
        check("illegal_p2_one_cycle", port2_valid, 0);
        check("illegal_nostart2", core_start, 0);
        tick();

        // Next command clears the error flag.
        load_op(4'h2, B_VAL);
        check("reload_b", core_b, sb_pop());
        ack_done("reload_b");
        tick();

        // Reset while waiting on the core; a late core_done must be ignored.
        send_cmd(4'h4);
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_all_zero("wait_reset");
        core_result = R_LATE;
        core_done   = 1'b1;
        tick();
        core_done = 1'b0;
        check_all_zero("late_done");
        send_cmd(4'h5);
        tick();
        check("post_reset_store_valid", bram_dout_valid, 1);
        check("post_reset_store_data", bram_dout, 0);
        bram_dout_read = 1'b1;
        tick();
        bram_dout_read = 1'b0;
        ack_done("post_reset_store");
        tick();

        // Core never answers: watchdog (if built in) completes the command.
        send_cmd(4'h4);
        tick();
        check("to_start", core_start, 1);
        n = 0;
        while (n < 64 && port2_valid !== 1'b1) begin
            tick();
            n++;
        end
`ifdef MONT_CMD_TIMEOUT_EN
        check("to_cycles", n, 16);
        check("to_status", status, 8'h44);
        ack_done("timeout");
        tick();
        core_result = R_LATE;
        core_done   = 1'b1;
        tick();
        core_done = 1'b0;
        check("to_late_done_p2", port2_valid, 0);
`else
        check("no_to_p2valid", port2_valid, 0);
        check("no_to_status", status, 8'h04);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check_all_zero("final_reset");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
